ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter INIT_FILE, default "", hex image preloaded into the shared 16x8 memory when non-empty.
REQ-002 SHALL have port clk, input, 1: 12 MHz system clock; one clock domain, all state on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port a_req, input, 1: requester A access request.
REQ-005 SHALL have port a_we, input, 1: A access type; 1 is a write, 0 is a read.
REQ-006 SHALL have port a_addr, input, 4: A word address.
REQ-007 SHALL have port a_wdata, input, 8: A write data.
REQ-008 SHALL have port a_gnt, output, 1: A access accepted this cycle.
REQ-009 SHALL have port a_rvalid, output, 1: A read data valid, one-cycle pulse.
REQ-010 SHALL have port a_rdata, output, 8: A read data.
REQ-011 SHALL have ports b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, identical to REQ-004 to REQ-010 for requester B.

Function
REQ-012 SHALL share one 16x8 synchronous RAM between A and B, with at most one access accepted per cycle.
REQ-013 SHALL implement a transfer as x_req high and x_gnt high at the same rising edge; a requester holds req, we, addr and wdata stable until granted.
REQ-014 SHALL drive x_gnt combinationally from x_req, the other requester's req, and the registered priority state; x_gnt is never high while x_req is low.
REQ-015 SHALL keep priority as a 1-bit FSM with states PRI_A and PRI_B; that requester wins when both request.
REQ-016 SHALL move the FSM, after a grant to A, to PRI_B, and after a grant to B, to PRI_A; with no grant the state holds.
REQ-017 SHALL grant a lone requester in the same cycle regardless of priority state, with zero idle cycles.
REQ-018 SHALL commit a write to memory at the accepting edge; no rvalid results.
REQ-019 SHALL present read data at the accepting edge plus one cycle: x_rvalid high for exactly one cycle, with x_rdata equal to memory[addr].
REQ-020 SHALL route a_rdata and b_rdata from the single RAM output register; only the port whose rvalid is high carries meaningful data.
REQ-021 SHALL hold rdata until the next accepted read, from either port.
REQ-022 SHALL return post-write data when a read follows a write to the same address in any later cycle.
REQ-023 SHALL tolerate back-to-back reads, alternating or same port, every cycle with no bubbles; the rvalid stream mirrors the accepted-read stream delayed by one cycle.
REQ-024 SHALL wrap address arithmetic modulo 16, with no out-of-range addresses possible.

Reset
REQ-025 SHALL force a_gnt and b_gnt low while rst is high, with no memory access accepted.
REQ-026 SHALL set the FSM to PRI_A, and a_rvalid and b_rvalid to 0, on reset.
REQ-027 SHALL suppress the rvalid owed by a read accepted in the cycle before rst.
REQ-028 SHALL not reset memory contents or the RAM output register; rdata is unspecified until the first rvalid.

Structure
REQ-029 SHALL place the RAM as sub-module ram_16x8: write enable and read enable, separate 4-bit read and write addresses, 8-bit registered read output, INIT_FILE passed through, and no reset, so it infers block RAM.
REQ-030 SHALL place ADDR_W=4, DATA_W=8 and the PRI_A/PRI_B encoding in shared package ram_arb_pkg.
REQ-031 SHALL keep the arbiter FSM and the rvalid owner register in ram_arbiter itself.

Verification
REQ-032 SHALL cover: A alone writes 0xA5 to address 3, then reads 3 -> a_gnt high each request cycle; a_rvalid one cycle after the read grant; a_rdata=0xA5; b_* idle.
REQ-033 SHALL cover: after reset, both req continuously reading addresses 1 and 2, preloaded 0x11 and 0x22 -> grants alternate A,B,A,B; rvalids alternate; data 0x11 and 0x22 respectively.
REQ-034 SHALL cover: B writes 0x7E to address 15 while A is stalled, then A reads 15 -> A granted the cycle after B, returning 0x7E.
REQ-035 SHALL cover: A read accepted, rst high the next cycle -> a_rvalid stays 0, FSM is PRI_A, and a pre-reset write to address 5 is still readable afterwards.
REQ-036 SHALL cover: rst held with both req high -> no gnt and memory unchanged; first cycle after release grants A.
REQ-037 SHALL cover: B requests 20 consecutive cycles with A requesting on every third -> A never waits more than 1 cycle.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths and arbiter priority encoding for the
// two-port RAM arbiter slice (ram_arbiter, ram_16x8).
package ram_arb_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  // Priority state: the named requester wins when both request.
  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_t;

endpackage : ram_arb_pkg

// File: rtl/ram_16x8.sv
// ram_16x8: 16 x 8 single-clock RAM with a registered read output.
// No reset on storage or output register, so it maps onto block RAM.
// Ports:
//   clk     - clock, all state on rising edge
//   i_we    - write enable; i_waddr/i_wdata written at the edge
//   i_waddr - write word address
//   i_wdata - write data
//   i_re    - read enable; r_rdata loads mem[i_raddr] at the edge
//   i_raddr - read word address
//   o_rdata - registered read data, held while i_re is low
module ram_16x8
  import ram_arb_pkg::*;
#(
  parameter INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: output register only changes on an enabled read.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : ram_16x8

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one ram_16x8 between requesters A and B, accepting
// at most one access per cycle with alternating priority on contention.
// Ports (x = a or b):
//   clk      - clock
//   rst      - synchronous active-high reset
//   x_req    - access request, held with x_we/x_addr/x_wdata until granted
//   x_we     - 1 = write, 0 = read
//   x_addr   - word address
//   x_wdata  - write data
//   x_gnt    - access accepted at the coming edge (combinational)
//   x_rvalid - one-cycle pulse, read data valid the cycle after acceptance
//   x_rdata  - read data from the shared RAM output register
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata
);

  pri_t              r_pri;
  pri_t              w_pri_nxt;
  logic              w_a_gnt;
  logic              w_b_gnt;
  logic              r_a_rvalid;
  logic              r_b_rvalid;
  logic              w_we;
  logic              w_re;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  // Grant: a lone requester always wins; on contention the priority
  // state decides. Nothing is accepted while rst is high.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (rst) begin
      w_a_gnt = 1'b0;
      w_b_gnt = 1'b0;
    end else begin
      w_a_gnt = a_req & (~b_req | (r_pri == PRI_A));
      w_b_gnt = b_req & (~a_req | (r_pri == PRI_B));
    end
  end

  // Priority next state: hand priority to the other side after a grant.
  always_comb begin
    w_pri_nxt = r_pri;
    if (w_a_gnt) begin
      w_pri_nxt = PRI_B;
    end else if (w_b_gnt) begin
      w_pri_nxt = PRI_A;
    end else begin
      w_pri_nxt = r_pri;
    end
  end

  // Priority state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pri <= PRI_A;
    end else begin
      r_pri <= w_pri_nxt;
    end
  end

  // Rvalid owner: remembers which port's read was accepted last edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= w_a_gnt & ~a_we;
      r_b_rvalid <= w_b_gnt & ~b_we;
    end
  end

  // Single RAM access path steered by whichever port was granted.
  always_comb begin
    w_addr  = b_addr;
    w_wdata = b_wdata;
    if (w_a_gnt) begin
      w_addr  = a_addr;
      w_wdata = a_wdata;
    end else begin
      w_addr  = b_addr;
      w_wdata = b_wdata;
    end
  end

  assign w_we = (w_a_gnt & a_we) | (w_b_gnt & b_we);
  assign w_re = (w_a_gnt & ~a_we) | (w_b_gnt & ~b_we);

  ram_16x8 #(
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_addr),
    .i_wdata(w_wdata),
    .i_re   (w_re),
    .i_raddr(w_addr),
    .o_rdata(w_rdata)
  );

  assign a_gnt = w_a_gnt;
  assign b_gnt = w_b_gnt;
  // A read accepted just before rst must not deliver its pulse during rst.
  assign a_rvalid = r_a_rvalid & ~rst;
  assign b_rvalid = r_b_rvalid & ~rst;
  assign a_rdata  = w_rdata;
  assign b_rdata  = w_rdata;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter. Inputs change 1 ns after a rising edge;
// grants are checked 1 ns later, registered outputs 1 ns after each edge.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  ram_arbiter #(.INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic       exp_a;
    logic       a_was_gnt;
    logic       prev_a_rd, prev_b_rd;
    int         a_wait;

    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 4'd0; a_wdata = 8'h00;
    b_req = 1'b0; b_we = 1'b0; b_addr = 4'd0; b_wdata = 8'h00;
    tick; tick;
    chk("rst_a_gnt", {7'd0, a_gnt}, 8'h00);
    chk("rst_b_gnt", {7'd0, b_gnt}, 8'h00);
    chk("rst_a_rvalid", {7'd0, a_rvalid}, 8'h00);
    chk("rst_b_rvalid", {7'd0, b_rvalid}, 8'h00);
    chk("rst_pri", {7'd0, dut.r_pri}, {7'd0, PRI_A});

    // A alone: write 0xA5 to 3, then read it back.
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 8'hA5;
    #1;
    chk("wr3_a_gnt", {7'd0, a_gnt}, 8'h01);
    chk("wr3_b_gnt", {7'd0, b_gnt}, 8'h00);
    tick;
    chk("wr3_no_rvalid", {7'd0, a_rvalid}, 8'h00);
    a_we = 1'b0;
    #1;
    chk("rd3_a_gnt", {7'd0, a_gnt}, 8'h01);
    tick;
    a_req = 1'b0;
    chk("rd3_a_rvalid", {7'd0, a_rvalid}, 8'h01);
    chk("rd3_a_rdata", a_rdata, 8'hA5);
    chk("rd3_b_rvalid", {7'd0, b_rvalid}, 8'h00);
    tick;
    chk("rd3_pulse_end", {7'd0, a_rvalid}, 8'h00);

    // Preload addresses 1, 2, 5 through port A.
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd1; a_wdata = 8'h11;
    tick;
    a_addr = 4'd2; a_wdata = 8'h22;
    tick;
    a_addr = 4'd5; a_wdata = 8'h55;
    tick;

    // Reset held with both requesting writes: nothing may be accepted.
    rst = 1'b1;
    a_addr = 4'd1; a_wdata = 8'hEE;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd2; b_wdata = 8'hDD;
    #1;
    chk("rsthold_a_gnt", {7'd0, a_gnt}, 8'h00);
    chk("rsthold_b_gnt", {7'd0, b_gnt}, 8'h00);
    tick;
    chk("rsthold2_gnt", {6'd0, a_gnt, b_gnt}, 8'h00);
    a_we = 1'b0; b_we = 1'b0;
    tick;

    // Release: both read continuously; grants alternate starting with A.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_a = ((i % 2) == 0);
      #1;
      chk($sformatf("alt%0d_gnt", i), {6'd0, a_gnt, b_gnt}, exp_a ? 8'h02 : 8'h01);
      tick;
      chk($sformatf("alt%0d_rv", i), {6'd0, a_rvalid, b_rvalid}, exp_a ? 8'h02 : 8'h01);
      chk($sformatf("alt%0d_data", i), exp_a ? a_rdata : b_rdata, exp_a ? 8'h11 : 8'h22);
    end

    // One more A grant so priority sits at PRI_B.
    b_req = 1'b0; a_addr = 4'd2;
    tick;
    chk("rd2_a_rdata", a_rdata, 8'h22);

    // B writes 0x7E to 15 while A (reading 15) is stalled.
    a_addr = 4'd15;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd15; b_wdata = 8'h7E;
    #1;
    chk("b15_gnt", {6'd0, a_gnt, b_gnt}, 8'h01);
    tick;
    b_req = 1'b0; b_we = 1'b0;
    #1;
    chk("a15_gnt", {7'd0, a_gnt}, 8'h01);
    tick;
    a_req = 1'b0;
    chk("a15_rvalid", {6'd0, a_rvalid, b_rvalid}, 8'h02);
    chk("a15_rdata", a_rdata, 8'h7E);

    // Read accepted, then rst the next cycle: its rvalid is dropped.
    a_req = 1'b1; a_addr = 4'd3;
    #1;
    chk("pre_rst_gnt", {7'd0, a_gnt}, 8'h01);
    tick;
    rst = 1'b1; a_req = 1'b0;
    #1;
    chk("rst_drop_rvalid", {7'd0, a_rvalid}, 8'h00);
    tick;
    chk("rst_drop_rvalid2", {7'd0, a_rvalid}, 8'h00);
    chk("rst_drop_pri", {7'd0, dut.r_pri}, {7'd0, PRI_A});
    rst = 1'b0;
    a_req = 1'b1; a_addr = 4'd5;
    tick;
    a_req = 1'b0;
    chk("rd5_rvalid", {7'd0, a_rvalid}, 8'h01);
    chk("rd5_rdata", a_rdata, 8'h55);

    // B requests 20 cycles; A raises a read every third cycle.
    b_req = 1'b1; b_addr = 4'd2;
    a_addr = 4'd1;
    a_wait = 0;
    for (int i = 0; i < 20; i++) begin
      if ((i % 3) == 0) a_req = 1'b1;
      #1;
      chk($sformatf("fair%0d_onehot", i), {6'd0, a_gnt, b_gnt},
          a_gnt ? 8'h02 : 8'h01);
      a_was_gnt = a_gnt;
      prev_a_rd = a_gnt;
      prev_b_rd = b_gnt;
      if (a_req && !a_gnt) a_wait++;
      else a_wait = 0;
      chk($sformatf("fair%0d_wait", i), (a_wait <= 1) ? 8'h01 : 8'h00, 8'h01);
      tick;
      chk($sformatf("fair%0d_rv", i), {6'd0, a_rvalid, b_rvalid},
          {6'd0, prev_a_rd, prev_b_rd});
      if (a_was_gnt) a_req = 1'b0;
    end
    b_req = 1'b0; a_req = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule : tb_ram_arbiter
